// File: rtl/dp_mem_responder.sv
// dp_mem_responder
//   Memory-side responder for the single-cycle datapath. It services instruction
//   fetches and data reads/writes from an internal word-addressed RAM. Each
//   access gets a programmable number of wait states and ends with a one-cycle
//   ihit/dhit pulse. Data requests have priority over instruction requests
//   when a new access is accepted. Once halt is seen in IDLE, the responder
//   stops servicing requests until nRST is asserted.
//
// Handshake: a request line (imemREN, dmemREN, dmemWEN) acts as "valid". It
//   must stay high until its hit pulse, which acts as "ready". If the line
//   drops before the hit, the access is aborted: no hit is produced and
//   nothing is written. If the line is still high in the hit cycle, the
//   request is accepted again as a new access.
//
// Ports:
//   CLK, nRST                     clock, asynchronous active-low reset
//   halt                          stop servicing (sampled only in IDLE)
//   imemREN/imemaddr/imemload     instruction fetch request/address/result
//   ihit                          instruction access complete (1 cycle)
//   dmemREN/dmemWEN/dmemaddr      data read/write request and address
//   dmemstore/dmemload            data to write / data read result
//   dhit                          data access complete (1 cycle)
//   init_wen/init_addr/init_data  RAM preload port, active in any state
//   halted                        responder has stopped servicing
//   icnt/dcnt                     saturating counts of ihit/dhit pulses
module dp_mem_responder #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        init_wen,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data,
    output logic        halted,
    output logic [31:0] icnt,
    output logic [31:0] dcnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, DBUSY, IBUSY, HALTED} state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     store_q;
    logic            wr_q;
    logic            ihit_q, dhit_q, halted_q;
    logic [31:0]     imemload_q, dmemload_q, icnt_q, dcnt_q;

    logic [31:0]     mem [DEPTH];

    logic            d_line;
    logic            commit_wr;

    // Address bits outside the word index are intentionally ignored.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{imemaddr[31:AW+2], imemaddr[1:0],
                                dmemaddr[31:AW+2], dmemaddr[1:0],
                                init_addr[31:AW+2], init_addr[1:0]};

    always_comb begin
        // The abort check follows the request line of the latched access kind.
        d_line    = wr_q ? dmemWEN : dmemREN;
        commit_wr = (state_q == DBUSY) && wr_q && dmemWEN && (cnt_q == 4'd0);
    end

    // RAM: no reset. A preload to the same word as a write commit on the same
    // edge is assigned last, so the preload value is kept.
    always_ff @(posedge CLK) begin
        if (commit_wr) mem[idx_q] <= store_q;
        if (init_wen)  mem[init_addr[AW+1:2]] <= init_data;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            store_q    <= 32'd0;
            wr_q       <= 1'b0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            halted_q   <= 1'b0;
            imemload_q <= 32'd0;
            dmemload_q <= 32'd0;
            icnt_q     <= 32'd0;
            dcnt_q     <= 32'd0;
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (dmemREN || dmemWEN) begin
                        state_q <= DBUSY;
                        idx_q   <= dmemaddr[AW+1:2];
                        store_q <= dmemstore;
                        wr_q    <= dmemWEN;
                        cnt_q   <= LAT_M1;
                    end else if (imemREN) begin
                        state_q <= IBUSY;
                        idx_q   <= imemaddr[AW+1:2];
                        cnt_q   <= LAT_M1;
                    end
                end
                DBUSY: begin
                    if (!d_line) begin
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        dhit_q <= 1'b1;
                        if (!wr_q) dmemload_q <= mem[idx_q];
                        if (dcnt_q != 32'hFFFF_FFFF) dcnt_q <= dcnt_q + 32'd1;
                        state_q <= IDLE;
                    end
                end
                IBUSY: begin
                    if (!imemREN) begin
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ihit_q     <= 1'b1;
                        imemload_q <= mem[idx_q];
                        if (icnt_q != 32'hFFFF_FFFF) icnt_q <= icnt_q + 32'd1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign halted   = halted_q;
    assign imemload = imemload_q;
    assign dmemload = dmemload_q;
    assign icnt     = icnt_q;
    assign dcnt     = dcnt_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder. Expected timing and data come from a
// transaction-level model: each access hits LAT cycles after its accept edge,
// and reads return the model word at index (addr/4) mod DEPTH.
module tb_dp_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        CLK, nRST, halt;
    logic        imemREN, dmemREN, dmemWEN, init_wen;
    logic [31:0] imemaddr, dmemaddr, dmemstore, init_addr, init_data;
    logic [31:0] imemload, dmemload, icnt, dcnt;
    logic        ihit, dhit, halted;

    dp_mem_responder #(.DEPTH(DEPTH), .LAT(LAT)) u_dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
        .init_wen(init_wen), .init_addr(init_addr), .init_data(init_data),
        .halted(halted), .icnt(icnt), .dcnt(dcnt)
    );

    // clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] mm [DEPTH];
    int          written_q[$];
    logic [31:0] last_iload, last_dload;
    logic [31:0] exp_icnt, exp_dcnt;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] rand_alias(input int w);
        return 32'(w * 4) + 32'($urandom_range(0, 3)) + 32'(DEPTH * 4) * 32'($urandom_range(0, 7));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        init_wen = 1'b1; init_addr = a; init_data = d;
        step();
        init_wen = 1'b0;
        mm[widx(a)] = d;
        written_q.push_back(widx(a));
    endtask

    // Data access held until its hit; address/store are scrambled after accept.
    task automatic d_access(input bit wr, input bit rd, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
        int n;
        logic [31:0] exp_load;
        exp_load = wr ? last_dload : mm[widx(a)];
        dmemWEN = wr; dmemREN = rd; dmemaddr = a; dmemstore = d;
        step();
        dmemaddr = $urandom; dmemstore = $urandom;
        n = 0;
        while (dhit !== 1'b1 && n < 40) begin step(); n++; end
        dmemWEN = 1'b0; dmemREN = 1'b0;
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        if (wr) begin
            mm[widx(a)] = d;
            written_q.push_back(widx(a));
        end
        last_dload = exp_load;
        exp_dcnt++;
        check({tag, "_load"}, dmemload, last_dload);
        check({tag, "_dcnt"}, dcnt, exp_dcnt);
    endtask

    task automatic i_access(input logic [31:0] a, input string tag);
        int n;
        imemREN = 1'b1; imemaddr = a;
        step();
        imemaddr = $urandom;
        n = 0;
        while (ihit !== 1'b1 && n < 40) begin step(); n++; end
        imemREN = 1'b0;
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        last_iload = mm[widx(a)];
        exp_icnt++;
        check({tag, "_load"}, imemload, last_iload);
        check({tag, "_icnt"}, icnt, exp_icnt);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ihit"}, {31'd0, ihit}, 32'd0);
        check({tag, "_dhit"}, {31'd0, dhit}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_imemload"}, imemload, 32'd0);
        check({tag, "_dmemload"}, dmemload, 32'd0);
        check({tag, "_icnt"}, icnt, 32'd0);
        check({tag, "_dcnt"}, dcnt, 32'd0);
    endtask

    initial begin
        int n, dc, ic, hits;
        logic [31:0] a, d, old;

        // reset and preload
        nRST = 1'b1; halt = 1'b0;
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; init_wen = 1'b0;
        imemaddr = '0; dmemaddr = '0; dmemstore = '0; init_addr = '0; init_data = '0;
        #2 nRST = 1'b0;
        #1 check_reset_state("reset");
        exp_icnt = 0; exp_dcnt = 0; last_iload = 0; last_dload = 0;
        preload(32'h10, 32'hDEADBEEF);
        preload(32'h30, 32'hCAFEF00D);
        for (int i = 0; i < 6; i++) preload($urandom_range(64, 4000), $urandom);

        // fetch held from the first edge after reset: hits in cycles 3 and 6
        @(posedge CLK); #1;
        nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h10;
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("hold_ihit_c%0d", c), {31'd0, ihit},
                  (c % (LAT + 1) == 0) ? 32'd1 : 32'd0);
            if (c == 3) begin
                check("hold_imemload", imemload, 32'hDEADBEEF);
                check("hold_icnt1", icnt, 32'd1);
            end
        end
        imemREN = 1'b0;
        check("hold_icnt2", icnt, 32'd2);
        exp_icnt = 2; last_iload = 32'hDEADBEEF;

        // simultaneous data and instruction requests: data wins
        imemREN = 1'b1; dmemREN = 1'b1; imemaddr = 32'h10; dmemaddr = 32'h10;
        step();
        n = 0; dc = -1; ic = -1;
        while (ic < 0 && n < 40) begin
            step(); n++;
            if (dhit === 1'b1 && dc < 0) begin dc = n; dmemREN = 1'b0; end
            if (ihit === 1'b1) begin ic = n; imemREN = 1'b0; end
        end
        imemREN = 1'b0; dmemREN = 1'b0;
        check("prio_dlat", 32'(dc), 32'(LAT));
        check("prio_ilat", 32'(ic), 32'(dc + LAT + 1));
        check("prio_imemload", imemload, 32'hDEADBEEF);
        check("prio_dmemload", dmemload, 32'hDEADBEEF);
        exp_icnt++; exp_dcnt++; last_iload = 32'hDEADBEEF; last_dload = 32'hDEADBEEF;

        // write then read back, directly and through an alias
        d_access(1'b1, 1'b0, 32'h20, 32'h12345678, "wr20");
        d_access(1'b0, 1'b1, 32'h20, 32'h0, "rd20");
        d_access(1'b0, 1'b1, 32'h20 + 32'(DEPTH * 4), 32'h0, "rd20_alias");
        check("rd20_value", dmemload, 32'h12345678);

        // both data lines high acts as a write
        d_access(1'b1, 1'b1, 32'h40, 32'h0BADCAFE, "wr_both");
        d_access(1'b0, 1'b1, 32'h40, 32'h0, "rd_both");

        // abort: write strobe held for a single cycle
        old = mm[8];
        dmemWEN = 1'b1; dmemaddr = 32'h20; dmemstore = 32'hBAD0BAD0;
        step();
        dmemWEN = 1'b0;
        hits = 0;
        for (int i = 0; i < LAT + 4; i++) begin step(); if (dhit === 1'b1) hits++; end
        check("abort_nohit", 32'(hits), 32'd0);
        check("abort_dcnt", dcnt, exp_dcnt);
        d_access(1'b0, 1'b1, 32'h20, 32'h0, "abort_rd");
        check("abort_ram", dmemload, old);

        // preload collides with a write commit to the same word: preload wins
        dmemWEN = 1'b1; dmemaddr = 32'h20; dmemstore = 32'hAAAA5555;
        step();
        for (int i = 0; i < LAT - 1; i++) step();
        init_wen = 1'b1; init_addr = 32'h20; init_data = 32'hC0FFEE00;
        step();
        init_wen = 1'b0; dmemWEN = 1'b0;
        check("coll_dhit", {31'd0, dhit}, 32'd1);
        exp_dcnt++; mm[8] = 32'hC0FFEE00;
        d_access(1'b0, 1'b1, 32'h20, 32'h0, "coll_rd");

        // preload on the edge a read completes: read returns the old word
        dmemREN = 1'b1; dmemaddr = 32'h30;
        step();
        for (int i = 0; i < LAT - 1; i++) step();
        init_wen = 1'b1; init_addr = 32'h30; init_data = 32'h5EED5EED;
        step();
        init_wen = 1'b0; dmemREN = 1'b0;
        check("rdcoll_dhit", {31'd0, dhit}, 32'd1);
        check("rdcoll_old", dmemload, 32'hCAFEF00D);
        exp_dcnt++; mm[12] = 32'h5EED5EED; last_dload = 32'hCAFEF00D;
        d_access(1'b0, 1'b1, 32'h30, 32'h0, "rdcoll_new");

        // randomized mixed traffic
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 2))
                0: d_access(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, $sformatf("rnd%0d_wr", k));
                1: d_access(1'b0, 1'b1, rand_alias(written_q[$urandom_range(0, written_q.size() - 1)]), 32'h0,
                            $sformatf("rnd%0d_rd", k));
                default: i_access(rand_alias(written_q[$urandom_range(0, written_q.size() - 1)]),
                                  $sformatf("rnd%0d_if", k));
            endcase
        end

        // halt raised during an instruction access
        imemREN = 1'b1; imemaddr = 32'h10;
        step();
        halt = 1'b1;
        n = 0;
        while (ihit !== 1'b1 && n < 40) begin step(); n++; end
        check("halt_pending_lat", 32'(n), 32'(LAT));
        check("halt_hitcycle_halted", {31'd0, halted}, 32'd0);
        imemREN = 1'b0; exp_icnt++;
        step();
        check("halt_halted", {31'd0, halted}, 32'd1);
        imemREN = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h10; halt = 1'b0;
        hits = 0;
        for (int i = 0; i < 10; i++) begin step(); if (ihit === 1'b1 || dhit === 1'b1) hits++; end
        check("halt_nohits", 32'(hits), 32'd0);
        check("halt_icnt", icnt, exp_icnt);
        check("halt_dcnt", dcnt, exp_dcnt);
        check("halt_stays", {31'd0, halted}, 32'd1);
        nRST = 1'b0;
        #1 check_reset_state("halt_reset");
        imemREN = 1'b0; dmemREN = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
